// File: rtl/controle_pkg.sv
// controle_pkg: shared states, opcodes, ALU codes and instruction classes for the multi-cycle controller
package controle_pkg;
  typedef enum logic [3:0] {
    S_IDLE   = 4'b0000,
    S_FETCH  = 4'b0001,
    S_DECODE = 4'b0010,
    S_EXEC   = 4'b0011,
    S_MEM    = 4'b0100,
    S_WB     = 4'b1111,
    S_TRAP   = 4'b1000
  } state_t;
  typedef enum logic [2:0] {CL_LW, CL_SW, CL_IALU, CL_R, CL_BR} class_t;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_ADDI = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_BNE  = 4'b1111;
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic imm);
    return f3 == 3'b000 ? (imm ? ALU_ADDI : ALU_ADD) :
           f3 == 3'b100 ? ALU_XOR :
           f3 == 3'b101 ? ALU_SRL :
           f3 == 3'b110 ? ALU_OR  :
           f3 == 3'b111 ? ALU_AND : ALU_ADD;
  endfunction
endpackage

// File: rtl/controle_multiciclo_if.sv
// controle_multiciclo_if: instruction/memory handshake inputs and control outputs of the controller
interface controle_multiciclo_if #(parameter int ALUC_W = 4);
  logic              instr_valid;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              zero;
  logic              mem_ready;
  logic              clear_trap;
  logic              irwrite;
  logic              pcwrite;
  logic              pcsrc;
  logic              regiwrite;
  logic              memwrite;
  logic              memread;
  logic              memtoreg;
  logic              alusrc;
  logic              branch;
  logic [ALUC_W-1:0] alucontrol;
  logic [3:0]        estado;
  logic              busy;
  logic              illegal;
  logic              mem_err;
  modport master (
    output instr_valid, opcode, funct3, funct7, zero, mem_ready, clear_trap,
    input  irwrite, pcwrite, pcsrc, regiwrite, memwrite, memread, memtoreg, alusrc, branch,
           alucontrol, estado, busy, illegal, mem_err
  );
  modport slave (
    input  instr_valid, opcode, funct3, funct7, zero, mem_ready, clear_trap,
    output irwrite, pcwrite, pcsrc, regiwrite, memwrite, memread, memtoreg, alusrc, branch,
           alucontrol, estado, busy, illegal, mem_err
  );
endinterface

// File: rtl/decod_instr.sv
// decod_instr: combinational RV32I-subset decode into class, ALU code, bne flag and legality
module decod_instr
  import controle_pkg::*;
#(
  parameter int ENABLE_BNE = 1
) (
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output class_t     o_cls,
  output logic [3:0] o_aluc,
  output logic       o_is_bne,
  output logic       o_legal
);
  logic w_f7z;
  logic w_sub;
  assign w_f7z = i_funct7 == F7_ZERO;
  assign w_sub = i_funct3 == 3'b000 && i_funct7 == F7_SUB;
  always_comb begin
    o_cls    = CL_R;
    o_aluc   = ALU_AND;
    o_is_bne = 1'b0;
    o_legal  = 1'b0;
    case (i_opcode)
      OP_LW: begin
        o_cls   = CL_LW;
        o_aluc  = ALU_ADD;
        o_legal = i_funct3 == 3'b010;
      end
      OP_SW: begin
        o_cls   = CL_SW;
        o_aluc  = ALU_ADD;
        o_legal = i_funct3 == 3'b010;
      end
      OP_IALU: begin
        o_cls   = CL_IALU;
        o_aluc  = alu_of(i_funct3, 1'b1);
        o_legal = i_funct3 inside {3'b000, 3'b100, 3'b110, 3'b111} || (i_funct3 == 3'b101 && w_f7z);
      end
      OP_R: begin
        o_cls   = CL_R;
        o_aluc  = w_sub ? ALU_SUB : alu_of(i_funct3, 1'b0);
        o_legal = w_sub || (w_f7z && i_funct3 inside {3'b000, 3'b100, 3'b101, 3'b110, 3'b111});
      end
      OP_BR: begin
        o_cls    = CL_BR;
        o_is_bne = i_funct3 == 3'b001;
        o_aluc   = i_funct3 == 3'b001 ? ALU_BNE : ALU_SUB;
        o_legal  = i_funct3 == 3'b000 || (i_funct3 == 3'b001 && ENABLE_BNE != 0);
      end
      default: o_legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: sequencing FSM with registered Moore control outputs for the multi-cycle datapath
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int ALUC_W      = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int ENABLE_BNE  = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  controle_multiciclo_if.slave bus
);
  state_t     r_state, w_next, w_done;
  class_t     r_cls, w_cls;
  logic [3:0] r_aluc, w_aluc;
  logic       r_bne, w_bne, r_legal, w_legal, w_taken, w_is_mem;
  logic [7:0] r_cnt;
  logic       r_fetch, r_pcsrc, r_regwrite, r_memwrite, r_memread;
  logic       r_memtoreg, r_alusrc, r_branch, r_busy, r_illegal, r_mem_err;
  decod_instr #(.ENABLE_BNE(ENABLE_BNE)) u_dec (
    .i_opcode (bus.opcode),
    .i_funct3 (bus.funct3),
    .i_funct7 (bus.funct7),
    .o_cls    (w_cls),
    .o_aluc   (w_aluc),
    .o_is_bne (w_bne),
    .o_legal  (w_legal)
  );
  always_comb begin
    w_next   = r_state;
    w_done   = bus.instr_valid ? S_FETCH : S_IDLE;
    w_taken  = r_bne ? !bus.zero : bus.zero;
    w_is_mem = r_cls == CL_LW || r_cls == CL_SW;
    case (r_state)
      S_IDLE:   w_next = bus.instr_valid ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = r_legal ? S_EXEC : S_TRAP;
      S_EXEC:   w_next = w_is_mem ? S_MEM : r_cls == CL_BR ? w_done : S_WB;
      S_MEM:    w_next = bus.mem_ready ? (r_cls == CL_LW ? S_WB : w_done) :
                         r_cnt == 8'(MEM_TIMEOUT) ? S_TRAP : S_MEM;
      S_WB:     w_next = w_done;
      S_TRAP:   w_next = bus.clear_trap ? S_IDLE : S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end
  // Decode is latched on entry to DECODE so DECODE already shows the new controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cls      <= CL_LW;
      r_aluc     <= 4'd0;
      r_bne      <= 1'b0;
      r_legal    <= 1'b0;
      r_cnt      <= 8'd0;
      r_fetch    <= 1'b0;
      r_pcsrc    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memtoreg <= 1'b0;
      r_alusrc   <= 1'b0;
      r_branch   <= 1'b0;
      r_busy     <= 1'b0;
      r_illegal  <= 1'b0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) begin
        r_cls      <= w_cls;
        r_aluc     <= w_aluc;
        r_bne      <= w_bne;
        r_legal    <= w_legal;
        r_alusrc   <= w_cls != CL_R;
        r_memtoreg <= w_cls == CL_LW || w_cls == CL_SW;
        r_branch   <= w_cls == CL_BR;
      end
      r_cnt      <= w_next != S_MEM ? 8'd0 : r_state == S_MEM ? r_cnt + 8'd1 : 8'd1;
      r_fetch    <= w_next == S_FETCH;
      r_regwrite <= w_next == S_WB;
      r_memread  <= w_next == S_MEM && r_cls == CL_LW;
      r_memwrite <= w_next == S_MEM && r_cls == CL_SW;
      r_pcsrc    <= r_state == S_EXEC && r_cls == CL_BR && w_taken;
      r_busy     <= w_next != S_IDLE;
      r_illegal  <= (r_state == S_DECODE && !r_legal) ||
                    (r_illegal && !(r_state == S_TRAP && bus.clear_trap));
      r_mem_err  <= (r_state == S_MEM && w_next == S_TRAP) ||
                    (r_mem_err && !(r_state == S_TRAP && bus.clear_trap));
    end
  end
  assign bus.estado     = r_state;
  assign bus.irwrite    = r_fetch;
  assign bus.pcwrite    = r_fetch;
  assign bus.pcsrc      = r_pcsrc;
  assign bus.regiwrite  = r_regwrite;
  assign bus.memwrite   = r_memwrite;
  assign bus.memread    = r_memread;
  assign bus.memtoreg   = r_memtoreg;
  assign bus.alusrc     = r_alusrc;
  assign bus.branch     = r_branch;
  assign bus.alucontrol = ALUC_W'(r_aluc);
  assign bus.busy       = r_busy;
  assign bus.illegal    = r_illegal;
  assign bus.mem_err    = r_mem_err;
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: directed vectors against two controller builds (bne enabled / disabled)
module tb_controle_multiciclo;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [21:0] tbl [12];
  controle_multiciclo_if #(.ALUC_W(4)) b0 ();
  controle_multiciclo_if #(.ALUC_W(4)) b1 ();
  controle_multiciclo #(.ALUC_W(4), .MEM_TIMEOUT(4), .ENABLE_BNE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));
  controle_multiciclo #(.ALUC_W(4), .MEM_TIMEOUT(15), .ENABLE_BNE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  assign b1.instr_valid = b0.instr_valid;
  assign b1.opcode      = b0.opcode;
  assign b1.funct3      = b0.funct3;
  assign b1.funct7      = b0.funct7;
  assign b1.zero        = b0.zero;
  assign b1.mem_ready   = b0.mem_ready;
  assign b1.clear_trap  = b0.clear_trap;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    b0.opcode = op;
    b0.funct3 = f3;
    b0.funct7 = f7;
    b0.instr_valid = 1'b1;
    step();
    b0.instr_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    tbl[0]  = {7'b0010011, 3'b100, 7'b0000000, 4'h4, 1'b1};
    tbl[1]  = {7'b0010011, 3'b101, 7'b0000000, 4'h5, 1'b1};
    tbl[2]  = {7'b0010011, 3'b101, 7'b0100000, 4'h0, 1'b0};
    tbl[3]  = {7'b0010011, 3'b000, 7'b0000000, 4'h3, 1'b1};
    tbl[4]  = {7'b0010011, 3'b111, 7'b0000000, 4'h0, 1'b1};
    tbl[5]  = {7'b0010011, 3'b110, 7'b0000000, 4'h1, 1'b1};
    tbl[6]  = {7'b0110011, 3'b000, 7'b0100000, 4'h6, 1'b1};
    tbl[7]  = {7'b0110011, 3'b110, 7'b0000000, 4'h1, 1'b1};
    tbl[8]  = {7'b0110011, 3'b101, 7'b0000000, 4'h5, 1'b1};
    tbl[9]  = {7'b0110011, 3'b000, 7'b0000001, 4'h0, 1'b0};
    tbl[10] = {7'b0000011, 3'b000, 7'b0000000, 4'h0, 1'b0};
    tbl[11] = {7'b1100011, 3'b100, 7'b0000000, 4'h0, 1'b0};
    b0.instr_valid = 1'b0;
    b0.opcode = 7'd0;
    b0.funct3 = 3'd0;
    b0.funct7 = 7'd0;
    b0.zero = 1'b0;
    b0.mem_ready = 1'b0;
    b0.clear_trap = 1'b0;
    #2 rst_n = 1'b0;
    step();
    check("rst_estado", b0.estado, 0);
    check("rst_busy", b0.busy, 0);
    check("rst_irwrite", b0.irwrite, 0);
    check("rst_alusrc", b0.alusrc, 0);
    check("rst_aluc", b0.alucontrol, 0);
    check("rst_illegal", b0.illegal, 0);
    rst_n = 1'b1;
    step();
    check("idle_hold", b0.estado, 0);
    fetch(7'b0110011, 3'b000, 7'b0000000);
    check("add_f_estado", b0.estado, 1);
    check("add_f_irwrite", b0.irwrite, 1);
    check("add_f_pcwrite", b0.pcwrite, 1);
    check("add_f_busy", b0.busy, 1);
    step();
    check("add_d_estado", b0.estado, 2);
    check("add_d_aluc", b0.alucontrol, 4'b0010);
    check("add_d_alusrc", b0.alusrc, 0);
    check("add_d_irwrite", b0.irwrite, 0);
    check("add_d_regw", b0.regiwrite, 0);
    step();
    check("add_e_estado", b0.estado, 3);
    check("add_e_regw", b0.regiwrite, 0);
    step();
    check("add_w_estado", b0.estado, 4'hF);
    check("add_w_regw", b0.regiwrite, 1);
    step();
    check("add_end_estado", b0.estado, 0);
    check("add_end_regw", b0.regiwrite, 0);
    check("add_end_busy", b0.busy, 0);
    fetch(7'b0000011, 3'b010, 7'b0000000);
    step();
    check("lw_d_aluc", b0.alucontrol, 4'b0010);
    check("lw_d_memtoreg", b0.memtoreg, 1);
    check("lw_d_alusrc", b0.alusrc, 1);
    step();
    check("lw_e_memread", b0.memread, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("lw_mem%0d_estado", i), b0.estado, 4);
      check($sformatf("lw_mem%0d_memread", i), b0.memread, 1);
    end
    b0.mem_ready = 1'b1;
    step();
    b0.mem_ready = 1'b0;
    check("lw_w_estado", b0.estado, 4'hF);
    check("lw_w_regw", b0.regiwrite, 1);
    check("lw_w_memtoreg", b0.memtoreg, 1);
    check("lw_w_memread", b0.memread, 0);
    step();
    check("lw_end_estado", b0.estado, 0);
    fetch(7'b0100011, 3'b010, 7'b0000000);
    step();
    step();
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("sw_mem%0d_memwrite", i), b0.memwrite, 1);
      check($sformatf("sw_mem%0d_regw", i), b0.regiwrite, 0);
    end
    b0.mem_ready = 1'b1;
    step();
    b0.mem_ready = 1'b0;
    check("sw_end_estado", b0.estado, 0);
    check("sw_end_memwrite", b0.memwrite, 0);
    check("sw_end_regw", b0.regiwrite, 0);
    fetch(7'b1100011, 3'b000, 7'b0000000);
    step();
    check("beq_d_aluc", b0.alucontrol, 4'b0110);
    check("beq_d_branch", b0.branch, 1);
    step();
    b0.zero = 1'b1;
    check("beq_e_pcsrc", b0.pcsrc, 0);
    step();
    check("beq_z1_pcsrc", b0.pcsrc, 1);
    check("beq_z1_estado", b0.estado, 0);
    step();
    check("beq_z1_pcsrc_drop", b0.pcsrc, 0);
    fetch(7'b1100011, 3'b000, 7'b0000000);
    step();
    step();
    b0.zero = 1'b0;
    step();
    check("beq_z0_pcsrc", b0.pcsrc, 0);
    fetch(7'b1100011, 3'b001, 7'b0000000);
    step();
    check("bne_d_aluc", b0.alucontrol, 4'b1111);
    step();
    check("bne_e_estado", b0.estado, 3);
    check("bne_off_estado", b1.estado, 4'b1000);
    check("bne_off_illegal", b1.illegal, 1);
    step();
    check("bne_pcsrc", b0.pcsrc, 1);
    b0.clear_trap = 1'b1;
    step();
    b0.clear_trap = 1'b0;
    check("bne_off_clr_estado", b1.estado, 0);
    check("bne_off_clr_illegal", b1.illegal, 0);
    fetch(7'b0000011, 3'b010, 7'b0000000);
    step();
    step();
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("to_mem%0d_memread", i), b0.memread, 1);
    end
    check("to_mem4_estado", b0.estado, 4);
    check("to_mem4_err", b0.mem_err, 0);
    step();
    check("to_trap_estado", b0.estado, 4'b1000);
    check("to_trap_err", b0.mem_err, 1);
    check("to_trap_memread", b0.memread, 0);
    b0.instr_valid = 1'b1;
    step();
    b0.instr_valid = 1'b0;
    check("trap_ignores_valid", b0.estado, 4'b1000);
    b0.clear_trap = 1'b1;
    step();
    b0.clear_trap = 1'b0;
    check("clr_estado", b0.estado, 0);
    check("clr_err", b0.mem_err, 0);
    check("clr_illegal", b0.illegal, 0);
    do_reset();
    fetch(7'b0000011, 3'b010, 7'b0000000);
    step();
    step();
    for (int i = 1; i <= 4; i++) step();
    check("late_mem4_estado", b0.estado, 4);
    b0.mem_ready = 1'b1;
    step();
    b0.mem_ready = 1'b0;
    check("late_wb_estado", b0.estado, 4'hF);
    check("late_wb_err", b0.mem_err, 0);
    check("late_wb_regw", b0.regiwrite, 1);
    step();
    fetch(7'b1111111, 3'b000, 7'b0000000);
    step();
    check("ill_d_estado", b0.estado, 2);
    step();
    check("ill_trap_estado", b0.estado, 4'b1000);
    check("ill_trap_flag", b0.illegal, 1);
    check("ill_trap_irwrite", b0.irwrite, 0);
    b0.clear_trap = 1'b1;
    step();
    b0.clear_trap = 1'b0;
    check("ill_clr_flag", b0.illegal, 0);
    for (int i = 0; i < 12; i++) begin
      logic [21:0] v;
      v = tbl[i];
      do_reset();
      fetch(v[21:15], v[14:12], v[11:5]);
      step();
      if (v[0]) check($sformatf("tbl%0d_aluc", i), b0.alucontrol, v[4:1]);
      step();
      check($sformatf("tbl%0d_estado", i), b0.estado, v[0] ? 32'd3 : 32'd8);
      check($sformatf("tbl%0d_illegal", i), b0.illegal, !v[0]);
    end
    do_reset();
    fetch(7'b0100011, 3'b010, 7'b0000000);
    step();
    step();
    step();
    check("rstmem_memwrite", b0.memwrite, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmem_memwrite_async", b0.memwrite, 0);
    check("rstmem_estado_async", b0.estado, 0);
    check("rstmem_busy_async", b0.busy, 0);
    step();
    rst_n = 1'b1;
    step();
    check("rstmem_after", b0.estado, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Parametrised successor to the per-state control-signal generator for the multi-cycle RV32I-subset datapath.
- Owns its sequencing FSM: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Previously the state came from outside.
- Handshakes with data memory through `mem_ready`, with a timeout.
- Resolves branches (beq, and bne when enabled) from the ALU zero flag, and flags illegal opcodes.

Parameters:
- ALUC_W, 4: width of alucontrol, must be ≥4; codes are zero-extended.
- MEM_TIMEOUT, 15: maximum cycles spent in MEM waiting for mem_ready before a trap; range 1..255.
- ENABLE_BNE, 1: 1 decodes bne (funct3 001); 0 treats it as illegal.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- instr_valid, input, 1: an instruction is available to fetch.
- opcode, input, 7: instr[6:0], sampled in DECODE.
- funct3, input, 3: instr[14:12].
- funct7, input, 7: instr[31:25].
- zero, input, 1: ALU zero flag, sampled in EXEC.
- mem_ready, input, 1: data memory has completed the access.
- clear_trap, input, 1: one-cycle pulse that leaves TRAP.
- irwrite, pcwrite, output, 1 each: IR load and PC+4 update (FETCH).
- pcsrc, output, 1: branch taken; selects the branch target.
- regiwrite, memwrite, memread, memtoreg, alusrc, branch, output, 1 each.
- alucontrol, output, ALUC_W.
- estado, output, 4: current state.
- busy, output, 1: state is not IDLE.
- illegal, mem_err, output, 1 each: sticky trap causes.

Behaviour:
- Moore FSM; all outputs are registered.
- Reset (async assert, sync release):
  - estado=IDLE.
  - All 1-bit outputs 0; alucontrol 0.
  - Decode latch and timeout counter cleared.
- State encoding: IDLE=0000, FETCH=0001, DECODE=0010, EXEC=0011, MEM=0100, WB=1111, TRAP=1000.
- IDLE: go to FETCH when instr_valid=1.
- FETCH (1 cycle): irwrite=1 and pcwrite=1, then DECODE.
- DECODE (1 cycle):
  - Latch the class and ALU code.
  - Legal encodings:
    - lw: 0000011/f3 010.
    - sw: 0100011/f3 010.
    - I-ALU: 0010011, with f3 000/100/110/111, and 101 only when funct7=0.
    - R: 0110011, with f3/f7 in add, sub, xor, srl, or, and.
    - branch: 1100011, with f3 000, and f3 001 when ENABLE_BNE=1.
  - Illegal encoding: set illegal=1 and go to TRAP.
  - Control outputs during DECODE are not 0; they carry the newly decoded alucontrol/alusrc/memtoreg/branch, with all write enables held at 0.
  - Any legal encoding proceeds to EXEC.
- alucontrol codes:
  - AND 0000, OR 0001, ADD 0010 (lw, sw, add), ADDI 0011 (addi only).
  - XOR 0100 (xor, xori), SRL 0101 (srl, srli), SUB 0110 (sub, beq), BNE 1111.
  - andi and ori use AND and OR.
- alusrc: 1 for I-ALU, lw, sw and branch; 0 for R.
- memtoreg: 1 for lw and sw, else 0.
- branch: 1 only for branch class.
- EXEC (1 cycle):
  - lw/sw go to MEM.
  - I-ALU/R go to WB.
  - Branch: pcsrc = (beq & zero) | (bne & ~zero); pcsrc is asserted one cycle in the next state (FETCH if instr_valid, else IDLE).
- MEM:
  - memread=1 (lw) or memwrite=1 (sw), held until mem_ready=1.
  - The counter increments each cycle without mem_ready.
  - mem_ready=1 in the same cycle as count==MEM_TIMEOUT: success wins.
  - Otherwise, count reaching MEM_TIMEOUT sets mem_err=1 and goes to TRAP; memread and memwrite drop to 0 there.
  - lw completes to WB.
  - sw completes to FETCH if instr_valid, else IDLE.
- WB (1 cycle): regiwrite=1 (memtoreg=1 for lw), then FETCH if instr_valid, else IDLE.
- TRAP:
  - All write enables 0; illegal/mem_err held.
  - clear_trap=1 clears both flags and goes to IDLE.
  - instr_valid is ignored in TRAP.
- rst_n low mid-operation forces the reset values in the same cycle, including clearing any pending write enable.
- Write enables (regiwrite, memwrite, pcwrite, irwrite) are never X. Outside their state they are 0.

Decomposition:
- Package `controle_pkg`:
  - State localparams.
  - Opcode constants (OP_LW, OP_SW, OP_IALU, OP_R, OP_BR).
  - ALU code constants.
  - Class enum (CL_LW, CL_SW, CL_IALU, CL_R, CL_BR).
- Sub-module `decod_instr`: combinational opcode/funct decode producing class, alu code, is_bne and legal. The FSM instantiates it and registers its outputs in DECODE.

Test Plan:
- add x (opcode 0110011, f3 000, f7 0000000), instr_valid=1: estado 1,2,3,F; alucontrol 0010; alusrc 0; regiwrite=1 only in WB; 4 cycles total.
- lw with mem_ready asserted 3 cycles into MEM: memread=1 for 3 cycles, then WB with regiwrite=1 and memtoreg=1. sw likewise: memwrite=1, regiwrite never 1.
- beq with zero=1, then with zero=0: pcsrc=1 for one cycle / pcsrc stays 0. bne (f3 001), zero=0: alucontrol 1111, pcsrc=1. Repeat with ENABLE_BNE=0: illegal=1 and estado=1000.
- lw with mem_ready held 0, MEM_TIMEOUT=4: mem_err=1 after 4 MEM cycles and memread drops. clear_trap pulse returns to IDLE with flags 0. Also mem_ready arriving on the timeout cycle → WB, no error.
- Opcode 1111111: TRAP with illegal=1. rst_n pulsed low during MEM of sw: memwrite=0 asynchronously, estado=0000.
